seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-and-add multiplier. It is the successor to the fixed 4-bit combinational array multiplier.
- Adds a selectable signed (two's-complement) or unsigned mode.
- Uses valid/ready handshakes on both input and output, so it can sit between registered stages in the SoC datapath.
- Trades latency for area: one partial product per clock, WIDTH iterations per operation.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden by users).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with the operands.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, product=0.
  - Internal accumulator, counter and sign flag cleared.
  - A reset mid-operation aborts the operation with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Handshake fires at an edge where in_valid && in_ready.
  - Latch magnitudes: if is_signed, |a| and |b| as unsigned WIDTH bits (the most-negative value maps to 2^(WIDTH-1)); otherwise a and b as-is.
  - Latch neg = is_signed & (a[MSB] ^ b[MSB]); clear accumulator and counter; go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: if the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator (carry kept), shift right by 1, and increment the counter.
  - After exactly WIDTH iterations, go to DONE.
  - At the final edge, product is registered as the magnitude, two's-complement negated if neg.
- DONE:
  - out_valid=1; product held stable while out_valid=1.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - in_ready=0 in DONE: no overlap.
- Latency:
  - Operands accepted at edge E0; out_valid is high after edge E0+WIDTH.
  - With out_ready held high, in_ready returns to 1 after edge E0+WIDTH+1.
  - Throughput: one result per WIDTH+2 cycles.
- Zero operands need no special casing: 0 × x gives 0 after the full latency.
- Signed range: (-2^(W-1))² = 2^(2W-2), which fits in 2W signed bits. No overflow case exists in either mode.
- Input signals are ignored outside IDLE; a, b and is_signed may change freely after acceptance.
- product retains its last value after out_valid falls until the next result is registered. The consumer must only use it while out_valid=1.
- out_valid and in_ready are never both high.

Decomposition:
- Shared package mult_pkg holds:
  - the FSM state enum typedef (IDLE/CALC/DONE, 2-bit encoding);
  - the default WIDTH constant;
  - a function abs_mag(value, is_signed) shared with future divider/MAC blocks.
- One sub-module is natural: seq_mult_datapath. It contains the accumulator, shifter, adder and final conditional negate.
- The top level keeps the FSM and handshake logic.

Test Plan:
- WIDTH=4, unsigned: a=15, b=15 → product=225 (8'hE1), out_valid first high exactly 4 edges after acceptance. Also a=7, b=5 → 35 and a=8, b=9 → 72, matching the old array multiplier.
- WIDTH=8, signed: a=-3 (8'hFD), b=5 → product=16'hFFF1 (-15). a=-128, b=-128 → 16'h4000 (16384). a=127, b=-128 → 16'hC080 (-16256).
- WIDTH=8, unsigned: a=8'hFF, b=8'hFF → 16'hFE01. Same bit patterns with is_signed=1 → 16'h0001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. product stays constant, in_ready stays 0, and a new in_valid is not accepted. Then raise out_ready; result is consumed once and in_ready rises on the next cycle.
- Reset mid-operation: drive rst_n low for one edge during CALC iteration 3. Next cycle: out_valid=0, product=0, in_ready=1. A subsequent 6×7 operation gives 42 with nominal latency.
- Randomised back-to-back run: 1000 random operand/mode triples with in_valid and out_ready both held high. Each product equals the reference a*b, and results arrive every WIDTH+2 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family: FSM encoding, default width and a
// magnitude helper reused by the divider/MAC blocks.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // value must already be sign-extended (signed) or zero-extended (unsigned) to MAX_WIDTH;
    // the caller truncates the result to its operand width.
    function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 is_signed);
        logic [MAX_WIDTH-1:0] res;
        res = value;
        if (is_signed && value[MAX_WIDTH-1]) begin
            res = ~value + {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-and-add datapath: one partial product per step, with the sign applied to the
// magnitude product at the final step.
module seq_mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    input  logic                 i_neg,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_last;

    // Lower half holds the remaining multiplier bits; the sum carry shifts into the top.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     ({1'b0, r_mcand} & {(WIDTH+1){r_acc[0]}});
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        w_result   = r_neg ? (~w_acc_next + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_acc_next;
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (i_load) begin
            r_mcand <= i_mcand;
            r_acc   <= {{WIDTH{1'b0}}, i_mplier};
            r_cnt   <= '0;
            r_neg   <= i_neg;
        end else if (i_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign o_last    = w_last;
    assign o_product = r_product;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle signed/unsigned multiplier with valid/ready on both sides; one result
// every WIDTH+2 cycles.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    mult_state_e r_state;
    mult_state_e w_state_next;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic                 w_neg;
    logic [MAX_WIDTH-1:0] w_a_ext;
    logic [MAX_WIDTH-1:0] w_b_ext;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    // The most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        w_a_ext = is_signed ? MAX_WIDTH'($signed(a)) : MAX_WIDTH'(a);
        w_b_ext = is_signed ? MAX_WIDTH'($signed(b)) : MAX_WIDTH'(b);
        w_mag_a = WIDTH'(abs_mag(w_a_ext, is_signed));
        w_mag_b = WIDTH'(abs_mag(w_b_ext, is_signed));
        w_neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mcand   (w_mag_a),
        .i_mplier  (w_mag_b),
        .i_neg     (w_neg),
        .o_last    (w_last),
        .o_product (product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=4 and WIDTH=8: directed cases, backpressure,
// mid-operation reset and a back-to-back random run against a reference model.
module tb_seq_multiplier;

    logic clk;
    logic rst_n;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, s8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc4 = 0;
    int acc_cyc8 = 0;
    int prev_rise8 = 0;
    bit have_prev = 0;
    bit b2b = 0;
    bit ov4_prev = 0;
    bit ov8_prev = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .is_signed (1'b0),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .is_signed (s8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return sa * sb;
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid4 && in_ready4) begin
                q4.push_back({4'h0, a4} * {4'h0, b4});
                acc_cyc4 = cyc + 1;
            end
            chk("excl4", 64'(out_valid4 & in_ready4), 64'(0));
            if (out_valid4 && !ov4_prev) chk("lat4", 64'(cyc - acc_cyc4), 64'(4));
            if (out_valid4 && out_ready4) begin
                chk("sb4_nonempty", 64'(q4.size() != 0), 64'(1));
                if (q4.size() != 0) chk("prod4", 64'(product4), 64'(q4.pop_front()));
            end
            ov4_prev = out_valid4;

            if (in_valid8 && in_ready8) begin
                q8.push_back(ref8(a8, b8, s8));
                acc_cyc8 = cyc + 1;
            end
            chk("excl8", 64'(out_valid8 & in_ready8), 64'(0));
            if (out_valid8 && !ov8_prev) begin
                chk("lat8", 64'(cyc - acc_cyc8), 64'(8));
                if (b2b) begin
                    if (have_prev) chk("tput8", 64'(cyc - prev_rise8), 64'(10));
                    have_prev  = 1'b1;
                    prev_rise8 = cyc;
                end
            end
            if (out_valid8 && out_ready8) begin
                chk("sb8_nonempty", 64'(q8.size() != 0), 64'(1));
                if (q8.size() != 0) chk("prod8", 64'(product8), 64'(q8.pop_front()));
            end
            ov8_prev = out_valid8;
        end
    end

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                       input string tag);
        int n;
        n = 0;
        while (!in_ready4 && n < 40) begin tick(); n++; end
        a4 = a; b4 = b; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        n = 0;
        while (!out_valid4 && n < 40) begin tick(); n++; end
        chk({tag, "_valid"}, 64'(out_valid4), 64'(1));
        chk(tag, 64'(product4), 64'(exp));
        tick();
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready8 && n < 40) begin tick(); n++; end
        a8 = a; b8 = b; s8 = s; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        n = 0;
        while (!out_valid8 && n < 40) begin tick(); n++; end
        chk({tag, "_valid"}, 64'(out_valid8), 64'(1));
        chk(tag, 64'(product8), 64'(exp));
        tick();
    endtask

    initial begin
        int n;
        int count;
        bit acc;

        rst_n = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready4", 64'(in_ready4), 64'(1));
        chk("rst_out_valid4", 64'(out_valid4), 64'(0));
        chk("rst_product4", 64'(product4), 64'(0));
        chk("rst_in_ready8", 64'(in_ready8), 64'(1));
        chk("rst_out_valid8", 64'(out_valid8), 64'(0));
        chk("rst_product8", 64'(product8), 64'(0));
        rst_n = 1'b1;
        tick();

        op4(4'd15, 4'd15, 8'hE1, "u4_15x15");
        op4(4'd7, 4'd5, 8'd35, "u4_7x5");
        op4(4'd8, 4'd9, 8'd72, "u4_8x9");

        op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s8_m3x5");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s8_m128xm128");
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s8_127xm128");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8_ffxff");
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s8_m1xm1");
        op8(8'h00, 8'h9C, 1'b1, 16'h0000, "s8_zero");

        // Backpressure: result must hold and no new operand may be taken.
        out_ready8 = 1'b0;
        a8 = 8'd12; b8 = 8'd11; s8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin tick(); n++; end
        chk("bp_valid", 64'(out_valid8), 64'(1));
        a8 = 8'd3; b8 = 8'd3; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_product", 64'(product8), 64'(16'd132));
            chk("bp_in_ready", 64'(in_ready8), 64'(0));
            chk("bp_out_valid", 64'(out_valid8), 64'(1));
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        chk("bp_consumed", 64'(out_valid8), 64'(0));
        chk("bp_in_ready_back", 64'(in_ready8), 64'(1));
        chk("bp_once", 64'(q8.size()), 64'(0));

        // Reset lands on the third CALC iteration.
        a8 = 8'd100; b8 = 8'd3; s8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_out_valid", 64'(out_valid8), 64'(0));
        chk("mid_rst_product", 64'(product8), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready8), 64'(1));
        q8.delete();
        op8(8'd6, 8'd7, 1'b0, 16'd42, "post_rst_6x7");

        // Back-to-back random run with both handshakes held high.
        b2b = 1'b1;
        have_prev = 1'b0;
        count = 0;
        n = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        in_valid8 = 1'b1;
        while (count < 1000 && n < 20000) begin
            acc = in_ready8;
            tick();
            n++;
            if (acc) begin
                count++;
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            end
        end
        in_valid8 = 1'b0;
        chk("rnd_count", 64'(count), 64'(1000));
        n = 0;
        while (q8.size() != 0 && n < 50) begin tick(); n++; end
        chk("rnd_drain8", 64'(q8.size()), 64'(0));
        chk("drain4", 64'(q4.size()), 64'(0));
        b2b = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
